// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
//   seg_t      - 8-bit segment vector {dp,g,f,e,d,c,b,a}
//   SEG_OFF    - active-low all-segments-off pattern
//   GLYPH_ROM  - active-high glyphs for hex values 0..F (dp bit clear)
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  localparam seg_t GLYPH_ROM [16] = '{
    8'h3f, 8'h06, 8'h5b, 8'h4f,
    8'h66, 8'h6d, 8'h7d, 8'h07,
    8'h7f, 8'h6f, 8'h77, 8'h7c,
    8'h39, 8'h5e, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational code-to-segment decoder.
//   code in 5 : bit 4 = decimal point, bits 3:0 = hex value
//   seg  out 8: active-high segments {dp,g,f,e,d,c,b,a}
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);

  seg_t glyph;

  always_comb begin
    glyph = GLYPH_ROM[code[3:0]];
    seg   = {code[4], glyph[6:0]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS common-anode
// 7-segment displays with per-frame brightness PWM, leading-zero
// suppression and frame-synchronous (tear-free) input capture.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_digits   : 5-bit code per digit, digit k at [5k+4:5k]
//   i_blank    : per-digit dark enable
//   i_lz_en    : leading-zero suppression enable
//   i_bright   : brightness 0 (1/16 duty) .. 15 (full duty)
//   o_seg      : active-low segments {dp,g,f,e,d,c,b,a}
//   o_dig_an   : active-low digit anodes, at most one low
//   o_frame    : one-cycle pulse at the first output cycle of each frame
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS*5-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_lz_en,
  input  logic [3:0]            i_bright,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig_an,
  output logic                  o_frame
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int PH_DIV = SCAN_DIV / 16;
  localparam int PH_W   = $clog2(PH_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PH_DIV - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [PH_W-1:0]       ph_sub;
  logic [3:0]            phase;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;

  logic [DIGITS*5-1:0]   sh_digits;
  logic [DIGITS-1:0]     sh_blank;
  logic                  sh_lz_en;
  logic [3:0]            sh_bright;

  logic [DIGITS-1:0]     suppress;
  logic                  zero_run;
  logic [4:0]            cur_code;
  seg_t                  cur_glyph;
  logic                  dig_on;
  seg_t                  seg_nxt;
  logic [DIGITS-1:0]     an_nxt;
  logic                  frame_nxt;

  seg_t                  seg_p1;
  logic [DIGITS-1:0]     an_p1;
  logic                  frame_p1;

  // ---- stage 0: scan counters and shadow capture ----
  // phase is tracked with its own prescaler rather than dividing div_cnt,
  // so no divider is needed for non-power-of-two SCAN_DIV.
  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      ph_sub  <= '0;
      phase   <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      ph_sub  <= '0;
      phase   <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (ph_sub == PH_LAST) begin
        ph_sub <= '0;
        phase  <= phase + 1'b1;
      end else begin
        ph_sub <= ph_sub + 1'b1;
      end
    end
  end

  // Shadow resets to all-blank so the first frame after reset is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_blank  <= '1;
      sh_lz_en  <= 1'b0;
      sh_bright <= 4'd0;
    end else if (frame_end) begin
      sh_digits <= i_digits;
      sh_blank  <= i_blank;
      sh_lz_en  <= i_lz_en;
      sh_bright <= i_bright;
    end
  end

  // Digit k is a leading zero when it and every higher digit hold code 0
  // (dp included); scan from the top down carrying the all-zero run.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (sh_digits[5*k +: 5] == 5'h00);
      suppress[k] = sh_lz_en && zero_run && (k != 0);
    end
  end

  assign cur_code = sh_digits[5*idx +: 5];

  seg7_glyph u_glyph (
    .code (cur_code),
    .seg  (cur_glyph)
  );

  // div_cnt == 0 is a forced dark cycle between slots to avoid ghosting.
  always_comb begin
    dig_on    = !sh_blank[idx] && !suppress[idx] &&
                (phase <= sh_bright) && (div_cnt != '0);
    seg_nxt   = SEG_OFF;
    an_nxt    = '1;
    if (dig_on) begin
      seg_nxt     = ~cur_glyph;
      an_nxt[idx] = 1'b0;
    end
    frame_nxt = (idx == '0) && (div_cnt == '0);
  end

  // ---- stage 1: registered pin outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1   <= SEG_OFF;
      an_p1    <= '1;
      frame_p1 <= 1'b0;
    end else begin
      seg_p1   <= seg_nxt;
      an_p1    <= an_nxt;
      frame_p1 <= frame_nxt;
    end
  end

  assign o_seg    = seg_p1;
  assign o_dig_an = an_p1;
  assign o_frame  = frame_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 32;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [19:0] i_digits;
  logic [3:0]  i_blank;
  logic        i_lz_en;
  logic [3:0]  i_bright;
  logic [7:0]  o_seg;
  logic [3:0]  o_dig_an;
  logic        o_frame;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_buf [FRAME];
  logic [3:0] an_buf  [FRAME];
  logic       frm_buf [FRAME];

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_digits (i_digits),
    .i_blank  (i_blank),
    .i_lz_en  (i_lz_en),
    .i_bright (i_bright),
    .o_seg    (o_seg),
    .o_dig_an (o_dig_an),
    .o_frame  (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance negedges until o_frame is seen; n = cycles advanced.
  task automatic wait_frame(output int n);
    n = 0;
    while (o_frame !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (o_frame !== 1'b1) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // Record one frame starting at the current sample (frame position 0).
  task automatic grab_frame(input int chg_at, input logic [19:0] chg_val);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      seg_buf[i] = o_seg;
      an_buf[i]  = o_dig_an;
      frm_buf[i] = o_frame;
      if (i == chg_at) i_digits = chg_val;
    end
  endtask

  // Inputs set before calling are displayed in the grabbed frame.
  task automatic show_grab();
    int n;
    @(negedge clk);
    wait_frame(n);
    @(negedge clk);
    wait_frame(n);
    grab_frame(-1, 20'h0);
  endtask

  function automatic int lit_cnt(input int d, input logic [3:0] an_exp);
    int c = 0;
    for (int i = 0; i < SCAN_DIV; i++)
      if (an_buf[d*SCAN_DIV + i] == an_exp) c++;
    return c;
  endfunction

  function automatic int dark_errs();
    int c = 0;
    for (int i = 0; i < FRAME; i++)
      if (seg_buf[i] != 8'hFF || an_buf[i] != 4'hF) c++;
    return c;
  endfunction

  function automatic int frm_cnt();
    int c = 0;
    for (int i = 0; i < FRAME; i++)
      if (frm_buf[i]) c++;
    return c;
  endfunction

  initial begin
    int n;
    int bad_hot, bad_slot0, bad_frm, zeros;

    rst_n    = 1'b1;
    i_digits = 20'h1E900;  // {03, 1a, 08, 00}
    i_blank  = 4'h0;
    i_lz_en  = 1'b0;
    i_bright = 4'd15;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", o_seg, 8'hFF);
    chk("rst_an", o_dig_an, 4'hF);
    chk("rst_frame", o_frame, 1'b0);
    rst_n = 1'b1;

    // Frame 1 after reset is dark, frame 2 shows the inputs
    wait_frame(n);
    chk("first_frame_lat", n, 1);
    grab_frame(-1, 20'h0);
    chk("f1_dark", dark_errs(), 0);
    chk("f1_frm_pulses", frm_cnt(), 1);
    @(negedge clk);
    chk("frame_period", o_frame, 1'b1);
    grab_frame(-1, 20'h0);
    chk("f2_d0_seg", seg_buf[5], 8'hC0);
    chk("f2_d0_an", an_buf[5], 4'hE);
    chk("f2_d1_seg", seg_buf[37], 8'h80);
    chk("f2_d1_an", an_buf[37], 4'hD);
    chk("f2_d2_seg", seg_buf[69], 8'h08);
    chk("f2_d2_an", an_buf[69], 4'hB);
    chk("f2_d3_seg", seg_buf[101], 8'hB0);
    chk("f2_d3_an", an_buf[101], 4'h7);
    chk("f2_dead_slot", an_buf[32], 4'hF);
    chk("f2_lit_full", lit_cnt(1, 4'hD), 31);

    // Leading-zero suppression
    i_digits = 20'h000A0;  // {00, 00, 05, 00}
    i_lz_en  = 1'b1;
    show_grab();
    chk("lz_d3_an", an_buf[101], 4'hF);
    chk("lz_d3_seg", seg_buf[101], 8'hFF);
    chk("lz_d2_an", an_buf[69], 4'hF);
    chk("lz_d1_seg", seg_buf[37], 8'h92);
    chk("lz_d0_seg", seg_buf[5], 8'hC0);
    i_digits = 20'h800A0;  // {10, 00, 05, 00}
    show_grab();
    chk("lzdp_d3_seg", seg_buf[101], 8'h40);
    chk("lzdp_d3_an", an_buf[101], 4'h7);
    chk("lzdp_d2_seg", seg_buf[69], 8'hC0);
    chk("lzdp_d2_an", an_buf[69], 4'hB);

    // PWM duty
    i_digits = 20'h1E900;
    i_lz_en  = 1'b0;
    i_bright = 4'd0;
    show_grab();
    chk("pwm0_d0", lit_cnt(0, 4'hE), 1);
    chk("pwm0_d1", lit_cnt(1, 4'hD), 1);
    chk("pwm0_d3", lit_cnt(3, 4'h7), 1);
    chk("pwm0_c1_an", an_buf[33], 4'hD);
    chk("pwm0_c1_seg", seg_buf[33], 8'h80);
    chk("pwm0_c2_an", an_buf[34], 4'hF);
    i_bright = 4'd7;
    show_grab();
    chk("pwm7_d1", lit_cnt(1, 4'hD), 15);
    chk("pwm7_d2", lit_cnt(2, 4'hB), 15);
    chk("pwm7_last_on", an_buf[47], 4'hD);
    chk("pwm7_first_off", an_buf[48], 4'hF);

    // Tear-free update: change mid-frame during digit 1
    i_bright = 4'd15;
    @(negedge clk);
    wait_frame(n);
    @(negedge clk);
    wait_frame(n);
    grab_frame(40, 20'h21C22);  // new {04, 07, 01, 02}
    chk("tear_d1_seg", seg_buf[50], 8'h80);
    chk("tear_d2_seg", seg_buf[69], 8'h08);
    chk("tear_d3_seg", seg_buf[101], 8'hB0);
    @(negedge clk);
    chk("tear_next_frame", o_frame, 1'b1);
    grab_frame(-1, 20'h0);
    chk("new_d0_seg", seg_buf[5], 8'hA4);
    chk("new_d1_seg", seg_buf[37], 8'hF9);
    chk("new_d2_seg", seg_buf[69], 8'hF8);
    chk("new_d3_seg", seg_buf[101], 8'h99);

    // Reset asserted mid-frame at digit 2
    @(negedge clk);
    repeat (70) @(negedge clk);
    chk("pre_rst_an", o_dig_an, 4'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", o_seg, 8'hFF);
    chk("async_rst_an", o_dig_an, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frame(n);
    chk("rst2_frame_lat", n, 1);
    grab_frame(-1, 20'h0);
    chk("rst2_dark", dark_errs(), 0);

    // Random inputs: anode one-cold and slot-start dead time
    @(negedge clk);
    wait_frame(n);
    bad_hot   = 0;
    bad_slot0 = 0;
    bad_frm   = 0;
    for (int c = 0; c < 10 * FRAME; c++) begin
      if (c > 0) @(negedge clk);
      zeros = 0;
      for (int b = 0; b < 4; b++)
        if (!o_dig_an[b]) zeros++;
      if (zeros > 1) bad_hot++;
      if ((c % SCAN_DIV) == 0 && o_dig_an != 4'hF) bad_slot0++;
      if (o_frame != ((c % FRAME) == 0)) bad_frm++;
      i_digits = 20'($urandom);
      i_blank  = 4'($urandom);
      i_lz_en  = 1'($urandom);
      i_bright = 4'($urandom);
    end
    chk("rand_one_cold", bad_hot, 0);
    chk("rand_slot0_dark", bad_slot0, 0);
    chk("rand_frame_pulse", bad_frm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment displays (with decimal point). Takes one 5-bit code per digit (bit 4 = decimal point, bits 3:0 = hex value), scans the digits in round-robin, and applies per-frame brightness PWM. It also supports leading-zero suppression and tear-free frame updates. It sits between the application datapath and the board's segment and anode pins.

## Interface
- `DIGITS`, default 8: number of multiplexed digits, 1..16.
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must be a multiple of 16 and at least 32.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_digits` in DIGITS*5: per-digit code; digit k occupies bits [5k+4:5k].
- `i_blank` in DIGITS: 1 = digit k is dark.
- `i_lz_en` in 1: enables leading-zero suppression.
- `i_bright` in 4: brightness level; 0 = 1/16 duty, 15 = full duty.
- `o_seg` out 8: segments {dp,g,f,e,d,c,b,a}, active-low.
- `o_dig_an` out DIGITS: digit anode enables, active-low, at most one low at a time.
- `o_frame` out 1: one-cycle pulse marking the start of each frame.

## Operation
- **Counters.**
  - `div_cnt` runs 0..SCAN_DIV-1.
  - `idx` runs 0..DIGITS-1 and advances when `div_cnt` wraps; it wraps to 0 after DIGITS-1.
  - `phase` = `div_cnt / (SCAN_DIV/16)`, range 0..15.
- **Shadow registers.** `i_digits`, `i_blank`, `i_lz_en` and `i_bright` are copied into shadow registers in the cycle where `idx == DIGITS-1` and `div_cnt == SCAN_DIV-1`. All display decisions use shadow values only. Input changes mid-frame never alter the frame in progress.
- **Glyph table.** Produces active-high segments, then inverted on output:
  - 0 → 3f, 1 → 06, 2 → 5b, 3 → 4f, 4 → 66, 5 → 6d, 6 → 7d, 7 → 07
  - 8 → 7f, 9 → 6f, A → 77, b → 7c, C → 39, d → 5e, E → 79, F → 71
  - Bit 7 (dp) = code bit 4.
- **Leading-zero suppression.** Digit k (k ≥ 1) is suppressed when `lz_en` is set and every digit j ≥ k has code == 5'h00, including dp = 0. Digit 0 is never suppressed.
- **Digit on.** Digit `idx` is on when all of the following hold:
  - not blanked;
  - not suppressed;
  - `phase <= bright`;
  - `div_cnt != 0` (one-cycle dead time at every slot start, to prevent ghosting).
- **Outputs when on:** `o_seg` = ~glyph and `o_dig_an` = ~(1 << idx).
- **Outputs when off:** `o_seg` = 8'hFF and `o_dig_an` = all ones.
- **Reset.**
  - Counters go to 0.
  - Shadow: `blank` = all ones, `bright` = 0, `lz_en` = 0, digits = 0.
  - `o_seg` = 8'hFF, `o_dig_an` = all ones, `o_frame` = 0.
- **Reset asserted mid-frame:** outputs return to reset values immediately (asynchronously). Scanning restarts at digit 0, slot cycle 0.

## Timing
- All outputs are registered. Counter state in cycle t determines outputs in cycle t+1.
- Slot = SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles.
- `o_frame` is high for exactly one cycle: the output cycle corresponding to `idx = 0`, `div_cnt = 0`. It pulses every frame, including the first frame after reset.
- The first frame after reset is dark because the shadow resets to blank. Inputs are first displayed in the second frame.
- Lit cycles per digit per frame: `(bright+1)*SCAN_DIV/16 - 1`.
- Input written in the same cycle as the shadow capture: the new value is captured.
- DIGITS = 1: `idx` stays 0 and the shadow captures at every slot end.

## Structure
- **`seg7_pkg`:** glyph constants, the all-off pattern 8'hFF, and a `seg_t` 8-bit typedef.
- **`seg7_glyph` (combinational sub-module):** 5-bit code in, active-high `seg_t` out. Instantiated once on the muxed shadow digit.
- **Top level:** counters, shadow registers, suppression logic, PWM compare, output registers.

## Test plan
All scenarios use DIGITS = 4, SCAN_DIV = 32.
- **Reset values.** Reset released with digits = {5'h03, 5'h1a, 5'h08, 5'h00}, blank = 0, bright = 15, lz_en = 0.
  - Frame 1: `o_seg` = FF and `o_dig_an` = F throughout.
  - Frame 2, digit 1: `o_seg` = 80 with `o_dig_an` = D.
  - Frame 2, digit 2: `o_seg` = 08 (A.) with `o_dig_an` = B.
  - Frame 2, digit 3: `o_seg` = B0 with `o_dig_an` = 7.
  - `o_frame` pulses every 128 cycles.
- **Leading zeros.** digits = {00, 00, 05, 00}, lz_en = 1 → digits 3 and 2 dark; digit 1 shows 92; digit 0 shows C0. Set dp on digit 3 (code 10) → digit 3 shows 40 and digit 2 shows C0.
- **PWM.** bright = 0 → each digit is lit for exactly 1 cycle per slot (slot cycle 1). bright = 7 → lit for 15 cycles.
- **Tear-free update.** Change `i_digits` at `idx = 1` mid-frame → digits 2 and 3 keep their old glyphs; new values appear from the next `o_frame`.
- **Reset mid-frame.** Assert `rst_n` low at `idx = 2` → `o_seg` = FF and `o_dig_an` = F within the same cycle. After release, the first `o_frame` occurs and that frame is dark.
- **Anode invariant.** With random inputs for 10 frames, `o_dig_an` never has more than one bit low, and it is all ones at every slot cycle 0.
